demux_1_4_64: RTL and testbench

Registered 1-to-4 demultiplexer for 64-bit datapath values: it routes one input stream to one of four output lanes. This is the inverse of the core's 4:1 datapath select. It is used where a single producer, such as a writeback or forwarding source, feeds four independent consumers. Each lane has a single-entry output register with a valid/ready handshake, so a stalled consumer holds only its own lane.

---
 rtl/demux_1_4_64_if.sv | 27 ++
 rtl/demux_1_4_64.sv | 56 +++++
 tb/tb_demux_1_4_64.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/demux_1_4_64_if.sv
// Producer-side and consumer-side signals of the registered 1-to-4 demultiplexer.
// The master modport is the environment: producer plus the four consumers.
interface demux_1_4_64_if #(
    parameter int WIDTH = 64
);
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       sel;
    logic [WIDTH-1:0] in_data;
    logic [3:0]       out_valid;
    logic [3:0]       out_ready;
    logic [WIDTH-1:0] out_data0;
    logic [WIDTH-1:0] out_data1;
    logic [WIDTH-1:0] out_data2;
    logic [WIDTH-1:0] out_data3;
    logic [2:0]       occupancy;

    modport master (
        output in_valid, sel, in_data, out_ready,
        input  in_ready, out_valid, out_data0, out_data1, out_data2, out_data3, occupancy
    );

    modport slave (
        input  in_valid, sel, in_data, out_ready,
        output in_ready, out_valid, out_data0, out_data1, out_data2, out_data3, occupancy
    );
endinterface

// File: rtl/demux_1_4_64.sv
// Registered 1-to-4 demultiplexer: one input stream routed by sel into four
// single-entry lanes, each with its own valid/ready handshake.
module demux_1_4_64 #(
    parameter int WIDTH = 64
) (
    input  logic           clk,
    input  logic           reset_n,
    demux_1_4_64_if.slave  bus
);
    logic [3:0]       v;
    logic [3:0]       v_next;
    logic [3:0]       load;
    logic [WIDTH-1:0] data [4];
    logic [2:0]       occ;
    logic [2:0]       occ_next;
    logic             accept;

    // A lane can take a beat if it is empty or being drained this cycle.
    assign bus.in_ready = ~v[bus.sel] | bus.out_ready[bus.sel];
    assign accept       = bus.in_valid & bus.in_ready;

    // NOTE: every always_comb output gets a default first, so no latch is inferred.
    always_comb begin
        load     = '0;
        v_next   = v;
        occ_next = '0;
        if (accept) load[bus.sel] = 1'b1;
        for (int k = 0; k < 4; k++) begin
            if (load[k])              v_next[k] = 1'b1;
            else if (bus.out_ready[k]) v_next[k] = 1'b0;
        end
        for (int k = 0; k < 4; k++) occ_next = occ_next + 3'(v_next[k]);
    end

    // NOTE: the payload registers are reset too, since the lanes must read zero after reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            v   <= '0;
            occ <= '0;
            for (int k = 0; k < 4; k++) data[k] <= '0;
        end else begin
            v   <= v_next;
            occ <= occ_next;
            for (int k = 0; k < 4; k++) begin
                if (load[k]) data[k] <= bus.in_data;
            end
        end
    end

    assign bus.out_valid = v;
    assign bus.occupancy = occ;
    assign bus.out_data0 = data[0];
    assign bus.out_data1 = data[1];
    assign bus.out_data2 = data[2];
    assign bus.out_data3 = data[3];
endmodule

// File: tb/tb_demux_1_4_64.sv
// Self-checking bench for demux_1_4_64: directed scenarios plus randomized
// traffic compared against a lane-array reference model.
module tb_demux_1_4_64;
    localparam int SW = 4 + 3 + 4 * 64;

    logic clk;
    logic reset_n;
    demux_1_4_64_if #(.WIDTH(64)) bus ();

    demux_1_4_64 #(.WIDTH(64)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks = 0;
    int errors = 0;

    // Reference model: each lane is simply "holds a value or not".
    logic        m_v    [4];
    logic [63:0] m_data [4];
    logic        got_ready;
    logic        exp_ready;

    function automatic logic [SW-1:0] exp_state();
        logic [3:0] vv;
        int         cnt;
        cnt = 0;
        for (int k = 0; k < 4; k++) begin
            vv[k] = m_v[k];
            cnt   = cnt + (m_v[k] ? 1 : 0);
        end
        return {vv, 3'(cnt), m_data[3], m_data[2], m_data[1], m_data[0]};
    endfunction

    function automatic logic [SW-1:0] got_state();
        return {bus.out_valid, bus.occupancy,
                bus.out_data3, bus.out_data2, bus.out_data1, bus.out_data0};
    endfunction

    task automatic model_clear();
        for (int k = 0; k < 4; k++) begin
            m_v[k]    = 1'b0;
            m_data[k] = '0;
        end
    endtask

    task automatic drive(input logic valid, input logic [1:0] s,
                         input logic [63:0] d, input logic [3:0] rdy);
        bus.in_valid  = valid;
        bus.sel       = s;
        bus.in_data   = d;
        bus.out_ready = rdy;
    endtask

    // One clock cycle: sample in_ready, advance the model, then step past the edge.
    task automatic tick();
        int s;
        #1;
        s         = int'(bus.sel);
        exp_ready = !m_v[s] || bus.out_ready[s];
        got_ready = bus.in_ready;
        for (int k = 0; k < 4; k++) begin
            if (m_v[k] && bus.out_ready[k]) m_v[k] = 1'b0;
        end
        if (bus.in_valid && exp_ready) begin
            m_v[s]    = 1'b1;
            m_data[s] = bus.in_data;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        drive(1'b0, 2'd0, '0, 4'b0000);
        @(negedge clk);
        reset_n = 1'b0;
        model_clear();
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        drive(1'b0, 2'd0, '0, 4'b0000);
        reset_n = 1'b0;
        model_clear();
        #2;
        checks++;
        if (got_state() !== exp_state()) begin
            errors++;
            $display("FAIL reset_state got=%h exp=%h", got_state(), exp_state());
        end
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready);
        end
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (got_state() !== exp_state()) begin
            errors++;
            $display("FAIL reset_release got=%h exp=%h", got_state(), exp_state());
        end
    endtask

    task automatic test_single_beat();
        do_reset();
        drive(1'b1, 2'b10, 64'h0123_4567_89AB_CDEF, 4'b0000);
        tick();
        drive(1'b0, 2'd0, '0, 4'b0000);
        checks++;
        if (got_ready !== 1'b1) begin
            errors++;
            $display("FAIL single_in_ready got=%b exp=1", got_ready);
        end
        checks++;
        if (bus.out_valid !== 4'b0100 || bus.out_data2 !== 64'h0123_4567_89AB_CDEF
            || bus.occupancy !== 3'd1) begin
            errors++;
            $display("FAIL single_beat got v=%b d2=%h occ=%0d exp v=0100 d2=0123456789abcdef occ=1",
                     bus.out_valid, bus.out_data2, bus.occupancy);
        end
        checks++;
        if (got_state() !== exp_state()) begin
            errors++;
            $display("FAIL single_others got=%h exp=%h", got_state(), exp_state());
        end
    endtask

    task automatic test_fill_stall();
        do_reset();
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 2'(k), 64'(k + 1), 4'b0000);
            tick();
        end
        checks++;
        if (bus.out_valid !== 4'b1111 || bus.occupancy !== 3'd4) begin
            errors++;
            $display("FAIL fill_full got v=%b occ=%0d exp v=1111 occ=4",
                     bus.out_valid, bus.occupancy);
        end
        drive(1'b1, 2'b01, 64'd5, 4'b0000);
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++;
            if (got_ready !== 1'b0) begin
                errors++;
                $display("FAIL fill_stall_ready cycle=%0d got=%b exp=0", c, got_ready);
            end
        end
        drive(1'b0, 2'd0, '0, 4'b0000);
        checks++;
        if (bus.out_data1 !== 64'd2) begin
            errors++;
            $display("FAIL fill_lane1_hold got=%h exp=2", bus.out_data1);
        end
        checks++;
        if (got_state() !== exp_state()) begin
            errors++;
            $display("FAIL fill_state got=%h exp=%h", got_state(), exp_state());
        end
    endtask

    task automatic test_drain_reload();
        do_reset();
        drive(1'b1, 2'b01, 64'hAA, 4'b0000);
        tick();
        drive(1'b1, 2'b01, 64'hBB, 4'b0010);
        tick();
        drive(1'b0, 2'd0, '0, 4'b0000);
        checks++;
        if (got_ready !== 1'b1) begin
            errors++;
            $display("FAIL reload_in_ready got=%b exp=1", got_ready);
        end
        checks++;
        if (bus.out_valid[1] !== 1'b1 || bus.out_data1 !== 64'hBB || bus.occupancy !== 3'd1) begin
            errors++;
            $display("FAIL reload got v1=%b d1=%h occ=%0d exp v1=1 d1=bb occ=1",
                     bus.out_valid[1], bus.out_data1, bus.occupancy);
        end
    endtask

    task automatic test_concurrent_drain();
        do_reset();
        drive(1'b1, 2'b00, 64'h10, 4'b0000);
        tick();
        drive(1'b1, 2'b11, 64'h13, 4'b0000);
        tick();
        drive(1'b1, 2'b10, 64'h12, 4'b1001);
        tick();
        drive(1'b0, 2'd0, '0, 4'b0000);
        checks++;
        if (bus.out_valid !== 4'b0100 || bus.occupancy !== 3'd1) begin
            errors++;
            $display("FAIL concurrent got v=%b occ=%0d exp v=0100 occ=1",
                     bus.out_valid, bus.occupancy);
        end
        checks++;
        if (got_state() !== exp_state()) begin
            errors++;
            $display("FAIL concurrent_state got=%h exp=%h", got_state(), exp_state());
        end
    endtask

    task automatic test_reset_midstream();
        do_reset();
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 2'(k), 64'hC0 + 64'(k), 4'b0000);
            tick();
        end
        drive(1'b0, 2'd0, '0, 4'b0000);
        checks++;
        if (bus.occupancy !== 3'd3) begin
            errors++;
            $display("FAIL mid_pre_occ got=%0d exp=3", bus.occupancy);
        end
        #2;
        reset_n = 1'b0;
        model_clear();
        #1;
        checks++;
        if (got_state() !== exp_state() || bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL mid_async_clear got=%h rdy=%b exp=%h rdy=1",
                     got_state(), bus.in_ready, exp_state());
        end
        @(negedge clk);
        reset_n = 1'b1;
        drive(1'b1, 2'b00, 64'hFEED_F00D_0000_0001, 4'b0000);
        tick();
        drive(1'b0, 2'd0, '0, 4'b0000);
        checks++;
        if (bus.out_valid !== 4'b0001 || bus.out_data0 !== 64'hFEED_F00D_0000_0001
            || bus.occupancy !== 3'd1) begin
            errors++;
            $display("FAIL mid_after got v=%b d0=%h occ=%0d exp v=0001 d0=feedf00d00000001 occ=1",
                     bus.out_valid, bus.out_data0, bus.occupancy);
        end
    endtask

    task automatic test_random();
        logic [3:0] rdy;
        do_reset();
        for (int c = 0; c < 500; c++) begin
            rdy = 4'($urandom) & 4'($urandom);
            drive(1'($urandom), 2'($urandom), {$urandom, $urandom}, rdy);
            tick();
            checks++;
            if (got_ready !== exp_ready) begin
                errors++;
                $display("FAIL rand_in_ready cycle=%0d got=%b exp=%b", c, got_ready, exp_ready);
            end
            checks++;
            if (got_state() !== exp_state()) begin
                errors++;
                $display("FAIL rand_state cycle=%0d got=%h exp=%h", c, got_state(), exp_state());
            end
        end
        drive(1'b0, 2'd0, '0, 4'b0000);
    endtask

    initial begin
        reset_n = 1'b1;
        drive(1'b0, 2'd0, '0, 4'b0000);
        model_clear();
        test_reset();
        test_single_beat();
        test_fill_stall();
        test_drain_reload();
        test_concurrent_drain();
        test_reset_midstream();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
